// File: rtl/csa_operand_packer.sv
// Streaming packer that collects W-bit operands into an N*W window for the CSA tree.
// Optional CSA_PACK_SUM_EN adds an incrementally accumulated reference sum on out_sum.
module csa_operand_packer #(
  parameter int N = 49,
  parameter int W = 4,
  parameter int E = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [W-1:0]               in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [N*W-1:0]             out_data,
  output logic [$clog2(N+1)-1:0]     out_cnt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W+E-1:0]             out_sum
);

  localparam int CW = $clog2(N+1);

  logic [N*W-1:0] fill_buf;
  logic [CW-1:0]  fill_cnt;
  logic           fill_done;
  logic           accept;
  logic           transfer;

  // in_ready depends only on registered state, never on out_ready
  assign in_ready = !fill_done;
  assign accept   = in_valid && in_ready;
  assign transfer = fill_done && (!out_valid || out_ready);

  // fill_cnt ends up holding the real operand count once the window is complete
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_buf  <= '0;
      fill_cnt  <= '0;
      fill_done <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
    end else if (transfer) begin
      out_data  <= fill_buf;
      out_cnt   <= fill_cnt;
      out_valid <= 1'b1;
      fill_buf  <= '0;
      fill_cnt  <= '0;
      fill_done <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        for (int k = 0; k < N; k++) begin
          if (fill_cnt == CW'(k)) begin
            fill_buf[k*W +: W] <= in_data;
          end
        end
        if (fill_cnt == CW'(N-1) || in_last) begin
          fill_done <= 1'b1;
        end
        fill_cnt <= fill_cnt + CW'(1);
      end
    end
  end

`ifdef CSA_PACK_SUM_EN
  logic [W+E-1:0] fill_sum;

  // Running sum avoids an N-input adder; it moves with the window on transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_sum <= '0;
      out_sum  <= '0;
    end else if (transfer) begin
      out_sum  <= fill_sum;
      fill_sum <= '0;
    end else if (accept) begin
      fill_sum <= fill_sum + {{E{1'b0}}, in_data};
    end
  end
`else
  assign out_sum = '0;
`endif

endmodule

// File: tb/tb_csa_operand_packer.sv
// Directed self-checking bench for csa_operand_packer: full/short/single windows,
// backpressure, back-to-back throughput and mid-window reset.
module tb_csa_operand_packer;

  localparam int N  = 49;
  localparam int W  = 4;
  localparam int E  = 6;
  localparam int CW = $clog2(N+1);

  logic              clk;
  logic              rst_n;
  logic [W-1:0]      in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [N*W-1:0]    out_data;
  logic [CW-1:0]     out_cnt;
  logic              out_valid;
  logic              out_ready;
  logic [W+E-1:0]    out_sum;

  int assertCount = 0;
  int failCount   = 0;
  int cycle       = 0;

  logic [N*W-1:0] dataQ[$];
  int             cntQ[$];
  int             sumQ[$];
  int             cycQ[$];

  logic [N*W-1:0] expData;

  csa_operand_packer #(.N(N), .W(W), .E(E)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Inputs only change just after a rising edge, so the negedge view is the handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      dataQ.push_back(out_data);
      cntQ.push_back(int'(out_cnt));
      sumQ.push_back(int'(out_sum));
      cycQ.push_back(cycle);
    end
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [255:0] sumExp(input int v);
`ifdef CSA_PACK_SUM_EN
    return 256'(v);
`else
    return 256'(v * 0);
`endif
  endfunction

  // Presents one operand and returns just after the edge that accepted it
  task automatic applyStimulus(input logic [W-1:0] d, input logic last);
    int budget;
    budget   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!in_ready) checkOutput("in_ready_wait", 256'(in_ready), 256'(1));
    @(posedge clk); #1;
  endtask

  task automatic goIdle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic waitWindows(input int n);
    int budget;
    budget = 0;
    while (dataQ.size() < n && budget < 500) begin
      @(posedge clk); #1;
      budget++;
    end
    checkOutput("window_count", 256'(dataQ.size()), 256'(n));
  endtask

  task automatic clearQueues();
    dataQ.delete();
    cntQ.delete();
    sumQ.delete();
    cycQ.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    goIdle();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 256'(in_ready), 256'(1));
    checkOutput("rst_out_valid", 256'(out_valid), 256'(0));
    checkOutput("rst_out_data", 256'(out_data), 256'(0));
    checkOutput("rst_out_cnt", 256'(out_cnt), 256'(0));
    checkOutput("rst_out_sum", 256'(out_sum), 256'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full window of incrementing values with two-cycle output latency
    out_ready = 1'b1;
    clearQueues();
    expData = '0;
    for (int k = 0; k < N; k++) begin
      expData[k*W +: W] = W'(k % 16);
      applyStimulus(W'(k % 16), 1'b0);
    end
    goIdle();
    checkOutput("full_lat_t1_valid", 256'(out_valid), 256'(0));
    checkOutput("full_lat_t1_ready", 256'(in_ready), 256'(0));
    @(posedge clk); #1;
    checkOutput("full_lat_t2_valid", 256'(out_valid), 256'(1));
    checkOutput("full_lat_t2_ready", 256'(in_ready), 256'(1));
    waitWindows(1);
    checkOutput("full_data", 256'(dataQ[0]), 256'(expData));
    checkOutput("full_cnt", 256'(cntQ[0]), 256'(49));
    checkOutput("full_sum", 256'(sumQ[0]), sumExp(360));

    // in_last while in_valid is low must not close the window
    clearQueues();
    in_last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_last_ready", 256'(in_ready), 256'(1));
    goIdle();

    // Short window, zero padded
    applyStimulus(4'd5, 1'b0);
    applyStimulus(4'd6, 1'b0);
    applyStimulus(4'd7, 1'b1);
    goIdle();
    waitWindows(1);
    expData = '0;
    expData[3:0]  = 4'd5;
    expData[7:4]  = 4'd6;
    expData[11:8] = 4'd7;
    checkOutput("short_data", 256'(dataQ[0]), 256'(expData));
    checkOutput("short_cnt", 256'(cntQ[0]), 256'(3));
    checkOutput("short_sum", 256'(sumQ[0]), sumExp(18));

    // Single operand window
    clearQueues();
    applyStimulus(4'd9, 1'b1);
    goIdle();
    waitWindows(1);
    checkOutput("single_data", 256'(dataQ[0]), 256'(9));
    checkOutput("single_cnt", 256'(cntQ[0]), 256'(1));
    checkOutput("single_sum", 256'(sumQ[0]), sumExp(9));

    // Backpressure: two full windows of 0xF with the output stalled
    clearQueues();
    out_ready = 1'b0;
    expData = '1;
    for (int k = 0; k < 2*N; k++) applyStimulus(4'hF, 1'b0);
    goIdle();
    checkOutput("bp_in_ready", 256'(in_ready), 256'(0));
    checkOutput("bp_valid", 256'(out_valid), 256'(1));
    checkOutput("bp_hold_data", 256'(out_data), 256'(expData));
    repeat (5) @(posedge clk);
    #1;
    checkOutput("bp_hold_data2", 256'(out_data), 256'(expData));
    checkOutput("bp_hold_cnt", 256'(out_cnt), 256'(49));
    checkOutput("bp_hold_sum", 256'(out_sum), sumExp(735));
    checkOutput("bp_in_ready2", 256'(in_ready), 256'(0));
    out_ready = 1'b1;
    waitWindows(2);
    for (int w = 0; w < 2; w++) begin
      checkOutput("bp_data", 256'(dataQ[w]), 256'(expData));
      checkOutput("bp_cnt", 256'(cntQ[w]), 256'(49));
      checkOutput("bp_sum", 256'(sumQ[w]), sumExp(735));
    end
    checkOutput("bp_no_bubble", 256'(cycQ[1] - cycQ[0]), 256'(1));

    // Back-to-back windows: one window per N+1 cycles
    clearQueues();
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < N; k++) applyStimulus(W'(w + 1), 1'b0);
    end
    goIdle();
    waitWindows(3);
    checkOutput("b2b_gap1", 256'(cycQ[1] - cycQ[0]), 256'(50));
    checkOutput("b2b_gap2", 256'(cycQ[2] - cycQ[1]), 256'(50));
    checkOutput("b2b_cnt", 256'(cntQ[2]), 256'(49));
    checkOutput("b2b_sum", 256'(sumQ[2]), sumExp(147));

    // Reset mid-window discards partial window and held output
    for (int k = 0; k < 20; k++) applyStimulus(4'd3, 1'b0);
    rst_n = 1'b0;
    #2;
    checkOutput("mid_rst_valid", 256'(out_valid), 256'(0));
    checkOutput("mid_rst_data", 256'(out_data), 256'(0));
    checkOutput("mid_rst_cnt", 256'(out_cnt), 256'(0));
    checkOutput("mid_rst_sum", 256'(out_sum), 256'(0));
    goIdle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("mid_rst_in_ready", 256'(in_ready), 256'(1));
    clearQueues();
    expData = '0;
    for (int k = 0; k < N; k++) begin
      expData[k*W +: W] = 4'd1;
      applyStimulus(4'd1, 1'b0);
    end
    goIdle();
    waitWindows(1);
    checkOutput("post_rst_data", 256'(dataQ[0]), 256'(expData));
    checkOutput("post_rst_cnt", 256'(cntQ[0]), 256'(49));
    checkOutput("post_rst_sum", 256'(sumQ[0]), sumExp(49));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
